// File: rtl/fifo_uart_tx.sv
// Serial transmitter that drains a synchronous FIFO with a one-cycle registered read
// latency and shifts each byte out as start bit, DATA_WIDTH data bits LSB first, one stop bit.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done,
  output logic [2:0]            state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_PREV = CW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cfg
    $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_STOP
  } state_t;

  // Handshake: fifo_r_en is a one-cycle read strobe, only issued when fifo_empty was low
  // in IDLE; the FIFO presents the popped word on fifo_data during the following cycle.
  state_t                state;
  logic [CW-1:0]         baud;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_shift;

  assign shreg_shift = shreg >> 1;
  assign state_dbg   = state;

  // Outputs are registered: each transition loads the value the next state drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tx        <= 1'b1;
      fifo_r_en <= 1'b0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      fifo_r_en <= 1'b0;
      tx_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable && !fifo_empty) begin
            state     <= S_FETCH;
            fifo_r_en <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          shreg   <= fifo_data;
          bit_idx <= '0;
          baud    <= '0;
          tx      <= 1'b0;
          state   <= S_START;
        end
        S_START: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            tx    <= shreg[0];
            state <= S_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_DATA: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            shreg   <= shreg_shift;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BIT_LAST) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              tx <= shreg_shift[0];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_STOP: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            baud <= baud + 1'b1;
            // Raise tx_done so it is high exactly in the final stop-bit cycle.
            if (baud == BAUD_PREV) tx_done <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO models with one-cycle read latency feed a default-rate
// instance and a CLKS_PER_BIT=2 instance; frames are checked cycle by cycle against the byte order.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  // default instance (CLKS_PER_BIT=16)
  logic       enable, fifo_empty = 1'b1, fifo_r_en, tx, busy, tx_done;
  logic [7:0] fifo_data = 8'h00;
  logic [2:0] state_dbg;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  // fast instance (CLKS_PER_BIT=2)
  logic       enable2, fifo_empty2 = 1'b1, fifo_r_en2, tx2, busy2, tx_done2;
  logic [7:0] fifo_data2 = 8'h00;
  logic [2:0] state_dbg2;
  logic [7:0] fifo_q2[$];
  logic [7:0] exp_q2[$];

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_r_en(fifo_r_en), .tx(tx), .busy(busy),
    .tx_done(tx_done), .state_dbg(state_dbg)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable2), .fifo_empty(fifo_empty2),
    .fifo_data(fifo_data2), .fifo_r_en(fifo_r_en2), .tx(tx2), .busy(busy2),
    .tx_done(tx_done2), .state_dbg(state_dbg2)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // FIFO models: registered read data, empty flag updates on the clock
  always @(posedge clk) begin
    if (fifo_r_en) begin
      if (fifo_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL fifo_underflow: read strobe with empty FIFO at cycle %0d", cyc);
      end else fifo_data <= fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(posedge clk) begin
    if (fifo_r_en2) begin
      if (fifo_q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL fifo2_underflow: read strobe with empty FIFO at cycle %0d", cyc);
      end else fifo_data2 <= fifo_q2.pop_front();
    end
    fifo_empty2 <= (fifo_q2.size() == 0);
  end

  function automatic logic tx_of(input int sel);   return (sel != 0) ? tx2 : tx; endfunction
  function automatic logic ren_of(input int sel);  return (sel != 0) ? fifo_r_en2 : fifo_r_en; endfunction
  function automatic logic busy_of(input int sel); return (sel != 0) ? busy2 : busy; endfunction
  function automatic logic done_of(input int sel); return (sel != 0) ? tx_done2 : tx_done; endfunction

  // driver tasks
  task automatic push(input int sel, input logic [7:0] b);
    if (sel != 0) begin fifo_q2.push_back(b); exp_q2.push_back(b); end
    else begin fifo_q.push_back(b); exp_q.push_back(b); end
  endtask

  // Wait for a read strobe, then check the whole frame: LOAD cycle, then
  // {stop, data, start} bits each held for cpb cycles, tx_done only in the last cycle.
  task automatic check_frame(input int sel, input bit drop_en, output int t_ren);
    int         cpb, waited;
    logic [7:0] exp;
    logic [9:0] frame;
    bit         bad_tx, bad_done, bad_ren, bad_busy;
    cpb = (sel != 0) ? 2 : 16;
    t_ren = -1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (ren_of(sel) !== 1'b1 && waited < 400);
    checks++;
    if (ren_of(sel) !== 1'b1) begin
      errors++;
      $display("FAIL frame_start(sel=%0d): fifo_r_en=%b after %0d cycles, required 1", sel, ren_of(sel), waited);
      return;
    end
    t_ren = cyc;
    if (sel != 0) exp = exp_q2.pop_front(); else exp = exp_q.pop_front();
    frame = {1'b1, exp, 1'b0};
    @(negedge clk);
    if (drop_en) enable = 1'b0;
    checks++;
    if (tx_of(sel) !== 1'b1 || ren_of(sel) !== 1'b0) begin
      errors++;
      $display("FAIL load_cycle(sel=%0d): tx=%b fifo_r_en=%b, required tx=1 fifo_r_en=0", sel, tx_of(sel), ren_of(sel));
    end
    bad_done = 0; bad_ren = 0; bad_busy = 0;
    for (int b = 0; b < 10; b++) begin
      bad_tx = 0;
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        if (tx_of(sel) !== frame[b]) bad_tx = 1;
        if (done_of(sel) !== ((b == 9) && (c == cpb - 1))) bad_done = 1;
        if (ren_of(sel) !== 1'b0) bad_ren = 1;
        if (busy_of(sel) !== 1'b1) bad_busy = 1;
      end
      checks++;
      if (bad_tx) begin
        errors++;
        $display("FAIL frame_bit(sel=%0d byte=%h bit=%0d): tx wrong during bit, required %b for %0d cycles", sel, exp, b, frame[b], cpb);
      end
    end
    checks++;
    if (bad_done) begin errors++; $display("FAIL tx_done_timing(sel=%0d byte=%h): pulse not solely in last stop cycle", sel, exp); end
    checks++;
    if (bad_ren) begin errors++; $display("FAIL ren_in_frame(sel=%0d byte=%h): fifo_r_en=1 seen mid-frame, required 0", sel, exp); end
    checks++;
    if (bad_busy) begin errors++; $display("FAIL busy_in_frame(sel=%0d byte=%h): busy=0 seen mid-frame, required 1", sel, exp); end
  endtask

  task automatic check_idle(input int sel, input int n, input string name);
    bit bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ren_of(sel) !== 1'b0 || tx_of(sel) !== 1'b1 || busy_of(sel) !== 1'b0 || done_of(sel) !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: activity seen while idle (last ren=%b tx=%b busy=%b), required ren=0 tx=1 busy=0", name, ren_of(sel), tx_of(sel), busy_of(sel));
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b1; enable2 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_r_en !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: tx=%b busy=%b ren=%b done=%b, required 1 0 0 0", tx, busy, fifo_r_en, tx_done);
    end
    checks++;
    if (tx2 !== 1'b1 || busy2 !== 1'b0 || fifo_r_en2 !== 1'b0 || tx_done2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs2: tx=%b busy=%b ren=%b done=%b, required 1 0 0 0", tx2, busy2, fifo_r_en2, tx_done2);
    end
    rst_n = 1'b1;
    check_idle(0, 20, "idle_after_reset");
    check_idle(1, 1, "idle_after_reset2");
  endtask

  task automatic test_single_byte;
    int t;
    push(0, 8'hA5);
    check_frame(0, 0, t);
    check_idle(0, 30, "idle_after_single");
  endtask

  task automatic test_back_to_back;
    int t_prev, t;
    logic [7:0] pat [4];
    pat = '{8'h00, 8'hFF, 8'h55, 8'h80};
    enable = 1'b0;
    foreach (pat[i]) push(0, pat[i]);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    check_frame(0, 0, t_prev);
    for (int i = 1; i < 4; i++) begin
      check_frame(0, 0, t);
      checks++;
      if (t - t_prev !== 163) begin
        errors++;
        $display("FAIL b2b_period(frame %0d): %0d cycles between reads, required 163", i, t - t_prev);
      end
      t_prev = t;
    end
    check_idle(0, 200, "last_byte_idle");
  endtask

  task automatic test_enable_drop;
    int t1, t2, t3, e;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) push(0, 8'($urandom_range(0, 255)));
    repeat (2) @(negedge clk);
    enable = 1'b1;
    check_frame(0, 0, t1);
    check_frame(0, 1, t2);
    checks++;
    if (t2 - t1 !== 163) begin
      errors++;
      $display("FAIL drop_period: %0d cycles between reads, required 163", t2 - t1);
    end
    check_idle(0, 60, "no_fetch_when_disabled");
    enable = 1'b1;
    e = cyc;
    check_frame(0, 0, t3);
    checks++;
    if (t3 - e !== 1) begin
      errors++;
      $display("FAIL reenable_latency: read strobe %0d cycles after enable edge, required 1", t3 - e);
    end
  endtask

  task automatic test_random_burst;
    int n, t_prev, t;
    n = $urandom_range(2, 5);
    enable = 1'b0;
    for (int i = 0; i < n; i++) push(0, 8'($urandom_range(0, 255)));
    repeat (2) @(negedge clk);
    enable = 1'b1;
    check_frame(0, 0, t_prev);
    for (int i = 1; i < n; i++) begin
      check_frame(0, 0, t);
      checks++;
      if (t - t_prev !== 163) begin
        errors++;
        $display("FAIL random_period(frame %0d): %0d cycles, required 163", i, t - t_prev);
      end
      t_prev = t;
    end
    check_idle(0, 10, "idle_after_random");
  endtask

  task automatic test_fast_baud;
    int t1, t2;
    push(1, 8'h01);
    push(1, 8'($urandom_range(0, 255)));
    check_frame(1, 0, t1);
    check_frame(1, 0, t2);
    checks++;
    if (t2 - t1 !== 23) begin
      errors++;
      $display("FAIL fast_period: %0d cycles between reads, required 23", t2 - t1);
    end
    check_idle(1, 10, "idle_after_fast");
  endtask

  task automatic test_reset_mid_frame;
    int waited;
    enable = 1'b1;
    fifo_q.push_back(8'h00);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (fifo_r_en !== 1'b1 && waited < 50);
    repeat (22) @(negedge clk);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_data: tx=%b busy=%b, required tx=0 busy=1", tx, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_r_en !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: tx=%b busy=%b ren=%b, required 1 0 0", tx, busy, fifo_r_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(0, 40, "no_retry_after_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    enable2 = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_enable_drop();
    test_random_burst();
    test_fast_baud();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
